reg_file_read_stage: RTL and testbench

//  Register file and decode/execute read stage; sits directly downstream of the register-address decoder.
//  - Takes three read addresses (plus per-port read enables) and returns registered operands to the ID/EX boundary.
//  - Accepts two write-back ports: port 1 = ALU/load result, port 2 = SP/base update from push/pop/LDM/STM.
//  - Models the Thumb PC-read offset and provides same-cycle write-through bypass.
//  - Optional load-use scoreboard raises a hazard to the stall logic.

---
 rtl/reg_file_read_stage.sv | 146 ++++++++++++++
 tb/tb_reg_file_read_stage.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_read_stage.sv
// Register file + ID/EX read stage: three registered read ports, two write-back
// ports, PC-read offset, write-through bypass. Scoreboard: REG_FILE_SCOREBOARD_EN.
module reg_file_read_stage #(
    parameter int                    ADDR_WIDTH   = 4,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] SP_RESET_VAL = 32'h0000_2000,
    parameter int                    PC_READ_OFS  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_WIDTH-1:0] reg_addr_1_i,
    input  logic [ADDR_WIDTH-1:0] reg_addr_2_i,
    input  logic [ADDR_WIDTH-1:0] reg_addr_3_i,
    input  logic [2:0]            reg_rd_en_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  wr_en_1_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_1_i,
    input  logic [DATA_WIDTH-1:0] wr_data_1_i,
    input  logic                  wr_en_2_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_2_i,
    input  logic [DATA_WIDTH-1:0] wr_data_2_i,
    input  logic                  mark_busy_i,
    input  logic [ADDR_WIDTH-1:0] mark_addr_i,
    output logic [DATA_WIDTH-1:0] reg_data_1_o,
    output logic [DATA_WIDTH-1:0] reg_data_2_o,
    output logic [DATA_WIDTH-1:0] reg_data_3_o,
    output logic                  hazard_o
);

    localparam int NREG = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_IDX = ADDR_WIDTH'(NREG - 1);
    localparam logic [ADDR_WIDTH-1:0] SP_IDX = ADDR_WIDTH'(13);

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic [ADDR_WIDTH-1:0] rd_addr [3];
    logic [DATA_WIDTH-1:0] rd_val [3];
    logic [NREG-1:0]       wr_hit_1;
    logic [NREG-1:0]       wr_hit_2;
    logic [DATA_WIDTH-1:0] pc_val;

    assign rd_addr[0] = reg_addr_1_i;
    assign rd_addr[1] = reg_addr_2_i;
    assign rd_addr[2] = reg_addr_3_i;
    assign pc_val     = pc_i + DATA_WIDTH'(PC_READ_OFS);

    always_comb begin
        wr_hit_1 = '0;
        wr_hit_2 = '0;
        for (int i = 0; i < NREG; i++) begin
            wr_hit_1[i] = wr_en_1_i && (wr_addr_1_i == ADDR_WIDTH'(i));
            wr_hit_2[i] = wr_en_2_i && (wr_addr_2_i == ADDR_WIDTH'(i));
        end
    end

    // r15 reads see the pipelined PC; otherwise bypass port 1, then port 2
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_val[p] = '0;
        end
        for (int p = 0; p < 3; p++) begin
            if (!reg_rd_en_i[p]) begin
                rd_val[p] = '0;
            end else if (rd_addr[p] == PC_IDX) begin
                rd_val[p] = pc_val;
            end else if (wr_hit_1[rd_addr[p]]) begin
                rd_val[p] = wr_data_1_i;
            end else if (wr_hit_2[rd_addr[p]]) begin
                rd_val[p] = wr_data_2_i;
            end else begin
                rd_val[p] = regs_q[rd_addr[p]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NREG; i++) begin
            if (!rst_n_i) begin
                regs_q[i] <= (ADDR_WIDTH'(i) == SP_IDX) ? SP_RESET_VAL : '0;
            end else if (ADDR_WIDTH'(i) != PC_IDX) begin
                if (wr_hit_1[i]) begin
                    regs_q[i] <= wr_data_1_i;
                end else if (wr_hit_2[i]) begin
                    regs_q[i] <= wr_data_2_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            reg_data_1_o <= '0;
            reg_data_2_o <= '0;
            reg_data_3_o <= '0;
        end else if (flush_i) begin
            reg_data_1_o <= '0;
            reg_data_2_o <= '0;
            reg_data_3_o <= '0;
        end else if (!stall_i) begin
            reg_data_1_o <= rd_val[0];
            reg_data_2_o <= rd_val[1];
            reg_data_3_o <= rd_val[2];
        end
    end

`ifdef REG_FILE_SCOREBOARD_EN
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] mark_hit;
    logic [NREG-1:0] wr_hit;

    assign wr_hit = wr_hit_1 | wr_hit_2;

    always_comb begin
        mark_hit = '0;
        for (int i = 0; i < NREG - 1; i++) begin
            mark_hit[i] = mark_busy_i && (mark_addr_i == ADDR_WIDTH'(i));
        end
    end

    // a new mark outranks a write-back clearing the same register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~wr_hit) | mark_hit;
        end
    end

    always_comb begin
        hazard_o = 1'b0;
        for (int p = 0; p < 3; p++) begin
            if (reg_rd_en_i[p] && busy_q[rd_addr[p]]
                && !wr_hit[rd_addr[p]]) begin
                hazard_o = 1'b1;
            end
        end
    end
`else
    logic unused_mark;

    assign unused_mark = ^{mark_busy_i, mark_addr_i};
    assign hazard_o    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_read_stage.sv
// Bench for reg_file_read_stage: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_reg_file_read_stage;

`ifdef REG_FILE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ra [3];
    logic [2:0]  rd_en;
    logic [31:0] pc;
    logic        stall, flush;
    logic        w1, w2, mark;
    logic [3:0]  wa1, wa2, maddr;
    logic [31:0] wd1, wd2;
    logic [31:0] obs [3];
    logic        hz;

    logic [31:0] m_mem [16];
    bit          m_busy [16];
    logic [31:0] m_out [3];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    reg_file_read_stage dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .reg_addr_1_i(ra[0]),
        .reg_addr_2_i(ra[1]),
        .reg_addr_3_i(ra[2]),
        .reg_rd_en_i (rd_en),
        .pc_i        (pc),
        .stall_i     (stall),
        .flush_i     (flush),
        .wr_en_1_i   (w1),
        .wr_addr_1_i (wa1),
        .wr_data_1_i (wd1),
        .wr_en_2_i   (w2),
        .wr_addr_2_i (wa2),
        .wr_data_2_i (wd2),
        .mark_busy_i (mark),
        .mark_addr_i (maddr),
        .reg_data_1_o(obs[0]),
        .reg_data_2_o(obs[1]),
        .reg_data_3_o(obs[2]),
        .hazard_o    (hz)
    );

    function automatic logic [31:0] m_read(int p);
        logic [3:0] a;
        a = ra[p];
        if (!rd_en[p]) return 32'h0;
        if (a == 4'd15) return pc + 32'd4;
        if (w1 && wa1 == a) return wd1;
        if (w2 && wa2 == a) return wd2;
        return m_mem[a];
    endfunction

    function automatic logic m_hazard();
        logic h;
        h = 1'b0;
        for (int p = 0; p < 3; p++) begin
            if (rd_en[p] && ra[p] != 4'd15 && m_busy[ra[p]]
                && !(w1 && wa1 == ra[p]) && !(w2 && wa2 == ra[p]))
                h = 1'b1;
        end
        return SB ? h : 1'b0;
    endfunction

    task automatic cycle();
        logic [31:0] rv [3];
        for (int p = 0; p < 3; p++) rv[p] = m_read(p);
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[i] = (i == 13) ? 32'h0000_2000 : 32'h0;
                m_busy[i] = 1'b0;
            end
            for (int p = 0; p < 3; p++) m_out[p] = 32'h0;
        end else begin
            if (flush) begin
                for (int p = 0; p < 3; p++) m_out[p] = 32'h0;
            end else if (!stall) begin
                for (int p = 0; p < 3; p++) m_out[p] = rv[p];
            end
            if (w2 && wa2 != 4'd15) m_mem[wa2] = wd2;
            if (w1 && wa1 != 4'd15) m_mem[wa1] = wd1;
            if (w1) m_busy[wa1] = 1'b0;
            if (w2) m_busy[wa2] = 1'b0;
            if (mark && maddr != 4'd15) m_busy[maddr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        rd_en = 3'b000;
        stall = 1'b0;
        flush = 1'b0;
        w1 = 1'b0;
        w2 = 1'b0;
        mark = 1'b0;
        wa1 = 4'd0;
        wa2 = 4'd0;
        wd1 = 32'h0;
        wd2 = 32'h0;
        maddr = 4'd0;
        pc = 32'h0;
        for (int p = 0; p < 3; p++) ra[p] = 4'd0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        w1 = 1'b1; wa1 = 4'd3; wd1 = 32'hFFFF_FFFF;
        stall = 1'b1; mark = 1'b1; maddr = 4'd4; rd_en = 3'b111;
        cycle();
        cycle();
        for (int p = 0; p < 3; p++) begin
            total++;
            if (obs[p] !== 32'h0) begin
                bad++;
                $display("FAIL reset_out%0d got=%h exp=0", p, obs[p]);
            end
        end
        idle();
        rst_n = 1'b1;
        ra[0] = 4'd13; ra[1] = 4'd0; ra[2] = 4'd3; rd_en = 3'b011;
        cycle();
        total++;
        if (obs[0] !== 32'h0000_2000) begin
            bad++;
            $display("FAIL reset_sp got=%h exp=00002000", obs[0]);
        end
        total++;
        if (obs[1] !== 32'h0) begin
            bad++;
            $display("FAIL reset_r0 got=%h exp=0", obs[1]);
        end
        total++;
        if (obs[2] !== 32'h0) begin
            bad++;
            $display("FAIL rd_en_mask got=%h exp=0", obs[2]);
        end
        rd_en = 3'b100;
        cycle();
        total++;
        if (obs[2] !== 32'h0) begin
            bad++;
            $display("FAIL reset_blocks_write got=%h exp=0", obs[2]);
        end
    endtask

    task automatic test_bypass();
        idle();
        w1 = 1'b1; wa1 = 4'd3; wd1 = 32'hDEAD_BEEF;
        ra[0] = 4'd3; rd_en = 3'b001;
        cycle();
        total++;
        if (obs[0] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL bypass_p1 got=%h exp=deadbeef", obs[0]);
        end
        idle();
        w2 = 1'b1; wa2 = 4'd7; wd2 = 32'h1234_5678;
        ra[1] = 4'd3; ra[2] = 4'd7; rd_en = 3'b110;
        cycle();
        total++;
        if (obs[1] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL array_keeps got=%h exp=deadbeef", obs[1]);
        end
        total++;
        if (obs[2] !== 32'h1234_5678) begin
            bad++;
            $display("FAIL bypass_p2 got=%h exp=12345678", obs[2]);
        end
    endtask

    task automatic test_priority_pc();
        idle();
        w1 = 1'b1; wa1 = 4'd5; wd1 = 32'd1;
        w2 = 1'b1; wa2 = 4'd5; wd2 = 32'd2;
        ra[0] = 4'd5; rd_en = 3'b001;
        cycle();
        total++;
        if (obs[0] !== 32'd1) begin
            bad++;
            $display("FAIL prio_bypass got=%h exp=1", obs[0]);
        end
        idle();
        ra[0] = 4'd5; rd_en = 3'b001;
        w1 = 1'b1; wa1 = 4'd15; wd1 = 32'hBAD0_BAD0;
        pc = 32'h100; ra[1] = 4'd15; rd_en = 3'b011;
        cycle();
        total++;
        if (obs[0] !== 32'd1) begin
            bad++;
            $display("FAIL prio_array got=%h exp=1", obs[0]);
        end
        total++;
        if (obs[1] !== 32'h104) begin
            bad++;
            $display("FAIL pc_write_ignored got=%h exp=104", obs[1]);
        end
        idle();
        pc = 32'hFFFF_FFFE; ra[2] = 4'd15; rd_en = 3'b100;
        cycle();
        total++;
        if (obs[2] !== 32'h2) begin
            bad++;
            $display("FAIL pc_wrap got=%h exp=2", obs[2]);
        end
    endtask

    task automatic test_stall_flush();
        idle();
        ra[0] = 4'd13; ra[1] = 4'd3; ra[2] = 4'd5; rd_en = 3'b111;
        cycle();
        idle();
        stall = 1'b1;
        ra[0] = 4'd1; ra[1] = 4'd2; ra[2] = 4'd15; rd_en = 3'b111;
        w1 = 1'b1; wa1 = 4'd13; wd1 = 32'hAAAA_5555;
        cycle();
        total++;
        if (obs[0] !== 32'h0000_2000 || obs[1] !== 32'hDEAD_BEEF
            || obs[2] !== 32'd1) begin
            bad++;
            $display("FAIL stall_hold got=%h/%h/%h exp=2000/deadbeef/1",
                     obs[0], obs[1], obs[2]);
        end
        w1 = 1'b0;
        flush = 1'b1;
        cycle();
        total++;
        if (obs[0] !== 32'h0 || obs[1] !== 32'h0 || obs[2] !== 32'h0) begin
            bad++;
            $display("FAIL flush_zero got=%h/%h/%h exp=0",
                     obs[0], obs[1], obs[2]);
        end
        idle();
        ra[0] = 4'd13; rd_en = 3'b001;
        cycle();
        total++;
        if (obs[0] !== 32'hAAAA_5555) begin
            bad++;
            $display("FAIL write_during_stall got=%h exp=aaaa5555", obs[0]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        mark = 1'b1; maddr = 4'd2;
        cycle();
        idle();
        ra[0] = 4'd2; rd_en = 3'b001;
        #1;
        total++;
        if (hz !== SB) begin
            bad++;
            $display("FAIL hz_busy got=%b exp=%b", hz, SB);
        end
        rd_en = 3'b000; ra[1] = 4'd2;
        #1;
        total++;
        if (hz !== 1'b0) begin
            bad++;
            $display("FAIL hz_masked got=%b exp=0", hz);
        end
        rd_en = 3'b001; flush = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        total++;
        if (hz !== SB) begin
            bad++;
            $display("FAIL hz_after_flush got=%b exp=%b", hz, SB);
        end
        w2 = 1'b1; wa2 = 4'd2; wd2 = 32'h77;
        #1;
        total++;
        if (hz !== 1'b0) begin
            bad++;
            $display("FAIL hz_wb_same_cycle got=%b exp=0", hz);
        end
        cycle();
        idle();
        mark = 1'b1; maddr = 4'd6;
        w1 = 1'b1; wa1 = 4'd6; wd1 = 32'h66;
        cycle();
        idle();
        mark = 1'b1; maddr = 4'd15;
        ra[0] = 4'd2; ra[1] = 4'd6; rd_en = 3'b001;
        #1;
        total++;
        if (hz !== 1'b0) begin
            bad++;
            $display("FAIL hz_cleared got=%b exp=0", hz);
        end
        rd_en = 3'b010;
        #1;
        total++;
        if (hz !== SB) begin
            bad++;
            $display("FAIL hz_set_wins got=%b exp=%b", hz, SB);
        end
        cycle();
        mark = 1'b0;
        ra[2] = 4'd15; rd_en = 3'b100;
        #1;
        total++;
        if (hz !== 1'b0) begin
            bad++;
            $display("FAIL hz_r15 got=%b exp=0", hz);
        end
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_n = 1'b1;
            for (int p = 0; p < 3; p++) ra[p] = 4'($urandom);
            rd_en = 3'($urandom);
            pc = $urandom;
            stall = ($urandom % 8) == 0;
            flush = ($urandom % 10) == 0;
            w1 = 1'($urandom);
            wa1 = 4'($urandom);
            wd1 = $urandom;
            w2 = ($urandom % 3) == 0;
            wa2 = (($urandom % 4) == 0) ? wa1 : 4'($urandom);
            wd2 = $urandom;
            mark = ($urandom % 4) == 0;
            maddr = 4'($urandom);
            if (($urandom % 3) == 0) ra[$urandom % 3] = wa1;
            #1;
            total++;
            if (hz !== m_hazard()) begin
                bad++;
                $display("FAIL rand_hz n=%0d got=%b exp=%b",
                         n, hz, m_hazard());
            end
            cycle();
            for (int p = 0; p < 3; p++) begin
                total++;
                if (obs[p] !== m_out[p]) begin
                    bad++;
                    $display("FAIL rand_out%0d n=%0d got=%h exp=%h",
                             p, n, obs[p], m_out[p]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        idle();
        w1 = 1'b1; wa1 = 4'd4; wd1 = 32'h4444;
        w2 = 1'b1; wa2 = 4'd13; wd2 = 32'hD00D;
        mark = 1'b1; maddr = 4'd9;
        cycle();
        mark = 1'b1; maddr = 4'd0;
        rst_n = 1'b0;
        cycle();
        idle();
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            logic [31:0] exp;
            ra[0] = 4'(a); rd_en = 3'b001; pc = 32'h40;
            exp = (a == 13) ? 32'h0000_2000 : (a == 15) ? 32'h44 : 32'h0;
            #1;
            total++;
            if (hz !== 1'b0) begin
                bad++;
                $display("FAIL rst_busy r%0d got=%b exp=0", a, hz);
            end
            cycle();
            total++;
            if (obs[0] !== exp || m_out[0] !== exp) begin
                bad++;
                $display("FAIL rst_reg r%0d got=%h exp=%h", a, obs[0], exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_priority_pc();
        test_stall_flush();
        test_scoreboard();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
